// File: rtl/pkt_proc_enq_arb_if.sv
// Enqueue-side bundle for pkt_proc_enq_arb: upstream source beats plus the
// packet-processor enqueue port. slave = arbiter view, master = source/processor view.
interface pkt_proc_enq_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 12,
  parameter int LVL_W   = 15
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_sop;
  logic [NUM_SRC-1:0]        src_eop;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*LEN_W-1:0]  src_len;
  logic [NUM_SRC-1:0]        src_ready;

  logic                      enq_req;
  logic                      in_sop;
  logic                      in_eop;
  logic [DATA_W-1:0]         wr_data_i;
  logic                      pck_len_valid;
  logic [LEN_W-1:0]          pck_len_i;
  logic                      pck_proc_full;
  logic [LVL_W-1:0]          pck_proc_wr_lvl;

  modport slave (
    input  src_valid, src_sop, src_eop, src_data, src_len,
    input  pck_proc_full, pck_proc_wr_lvl,
    output src_ready,
    output enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i
  );

  modport master (
    output src_valid, src_sop, src_eop, src_data, src_len,
    output pck_proc_full, pck_proc_wr_lvl,
    input  src_ready,
    input  enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i
  );
endinterface

// File: rtl/pkt_proc_enq_arb.sv
// Packet-atomic round-robin arbiter in front of the packet processor enqueue port.
// Optional per-source packet counters: define PKT_PROC_ENQ_ARB_STATS_EN.
//
// state | meaning
// IDLE  | pick next sop requester at/after rr_ptr; drop stray non-sop beats
// ADMIT | wait until the processor has room for the whole packet
// XFER  | stream granted source's beats, registered, until eop
module pkt_proc_enq_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 12,
  parameter int DEPTH   = 16384,
  parameter int LVL_W   = 15
) (
  input  logic                       pck_proc_int_mem_fsm_clk,
  input  logic                       pck_proc_int_mem_fsm_rstn,
  input  logic                       pck_proc_int_mem_fsm_sw_rstn,
  pkt_proc_enq_arb_if.slave          bus,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       len_err,
  output logic                       proto_err
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]      pkt_cnt
`endif
);

  localparam int GW = $clog2(NUM_SRC);
  localparam logic [LVL_W:0] DEPTH_LIM = DEPTH[LVL_W:0];

  typedef enum logic [1:0] {IDLE, ADMIT, XFER} state_t;

  typedef struct packed {
    state_t            state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     rr_ptr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    cnt;
    logic              enq_req;
    logic              in_sop;
    logic              in_eop;
    logic [DATA_W-1:0] data;
    logic              len_valid;
    logic [LEN_W-1:0]  len_i;
    logic              len_err;
    logic              proto_err;
  } regs_t;

  regs_t r;

  logic                clk;
  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  bad;
  logic                pick_vld;
  logic [GW-1:0]       pick;
  logic [LEN_W-1:0]    pick_len;
  logic [LEN_W-1:0]    pick_len_eff;
  logic                g_valid;
  logic                g_sop;
  logic                g_eop;
  logic [DATA_W-1:0]   g_data;
  logic [LEN_W-1:0]    g_len;
  logic [LVL_W:0]      need;
  logic                admit_ok;
  logic                accept;
  logic [LEN_W:0]      cnt_next;
  logic [GW-1:0]       rr_next;
  logic [NUM_SRC-1:0]  ready;

  assign clk = pck_proc_int_mem_fsm_clk;
  assign req = bus.src_valid & bus.src_sop;
  assign bad = bus.src_valid & ~bus.src_sop;

  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(r.rr_ptr) + k) % NUM_SRC;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  // A zero declared length still carries one beat, so it is admitted as 1.
  assign pick_len     = bus.src_len[int'(pick)*LEN_W +: LEN_W];
  assign pick_len_eff = (pick_len == '0) ? LEN_W'(1) : pick_len;

  assign g_valid = bus.src_valid[r.grant];
  assign g_sop   = bus.src_sop[r.grant];
  assign g_eop   = bus.src_eop[r.grant];
  assign g_data  = bus.src_data[int'(r.grant)*DATA_W +: DATA_W];
  assign g_len   = bus.src_len[int'(r.grant)*LEN_W +: LEN_W];

  assign need     = {1'b0, bus.pck_proc_wr_lvl} + {{(LVL_W+1-LEN_W){1'b0}}, r.len_q};
  assign admit_ok = (need <= DEPTH_LIM) && !bus.pck_proc_full;
  assign accept   = (r.state == XFER) && g_valid && !bus.pck_proc_full;
  assign cnt_next = r.cnt + 1'b1;
  assign rr_next  = (r.grant == GW'(NUM_SRC-1)) ? '0 : r.grant + 1'b1;

  // Gated by both resets so every output reads 0 while reset is held.
  always_comb begin
    ready = '0;
    if (pck_proc_int_mem_fsm_rstn && pck_proc_int_mem_fsm_sw_rstn) begin
      if (r.state == IDLE)
        ready = bad;
      else if (r.state == XFER)
        ready[r.grant] = ~bus.pck_proc_full;
    end
  end

  always_ff @(posedge clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) begin
      r <= '0;
    end else if (!pck_proc_int_mem_fsm_sw_rstn) begin
      r <= '0;
    end else begin
      r.enq_req   <= accept;
      r.in_sop    <= accept & g_sop;
      r.in_eop    <= accept & g_eop;
      r.data      <= accept ? g_data : '0;
      r.len_valid <= accept & g_sop;
      r.len_i     <= (accept && g_sop) ? g_len : '0;
      if (r.state == IDLE && |bad)
        r.proto_err <= 1'b1;
      case (r.state)
        IDLE: begin
          if (pick_vld) begin
            r.grant <= pick;
            r.len_q <= pick_len_eff;
            r.cnt   <= '0;
            r.state <= ADMIT;
          end
        end
        ADMIT: begin
          if (admit_ok)
            r.state <= XFER;
        end
        XFER: begin
          if (accept) begin
            r.cnt <= cnt_next;
            if (g_eop) begin
              if (cnt_next != {1'b0, r.len_q})
                r.len_err <= 1'b1;
              r.rr_ptr <= rr_next;
              r.state  <= IDLE;
            end
          end
        end
        default: r.state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready     = ready;
  assign bus.enq_req       = r.enq_req;
  assign bus.in_sop        = r.in_sop;
  assign bus.in_eop        = r.in_eop;
  assign bus.wr_data_i     = r.data;
  assign bus.pck_len_valid = r.len_valid;
  assign bus.pck_len_i     = r.len_i;
  assign grant_id          = r.grant;
  assign busy              = (r.state != IDLE);
  assign len_err           = r.len_err;
  assign proto_err         = r.proto_err;

`ifdef PKT_PROC_ENQ_ARB_STATS_EN
  logic [NUM_SRC-1:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) begin
      cnt_q <= '0;
    end else if (!pck_proc_int_mem_fsm_sw_rstn) begin
      cnt_q <= '0;
    end else if (accept && g_eop && cnt_q[r.grant] != 16'hFFFF) begin
      cnt_q[r.grant] <= cnt_q[r.grant] + 16'd1;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pkt_proc_enq_arb.sv
// Self-checking bench for pkt_proc_enq_arb: admission table, directed corner
// sequences and randomized multi-source traffic against a packet-level model.
module tb_pkt_proc_enq_arb;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int LW = 12;
  localparam int VW = 15;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sw_rstn = 1'b1;
  always #5 clk = ~clk;

  pkt_proc_enq_arb_if #(.NUM_SRC(NS), .DATA_W(DW), .LEN_W(LW), .LVL_W(VW)) bus ();

  logic [1:0] grant_id;
  logic       busy, len_err, proto_err;
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
  logic [NS*16-1:0] pkt_cnt;
`endif

  pkt_proc_enq_arb #(.NUM_SRC(NS), .DATA_W(DW), .LEN_W(LW), .DEPTH(16384), .LVL_W(VW)) dut (
    .pck_proc_int_mem_fsm_clk     (clk),
    .pck_proc_int_mem_fsm_rstn    (rstn),
    .pck_proc_int_mem_fsm_sw_rstn (sw_rstn),
    .bus                          (bus.slave),
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
    .pkt_cnt                      (pkt_cnt),
`endif
    .grant_id                     (grant_id),
    .busy                         (busy),
    .len_err                      (len_err),
    .proto_err                    (proto_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [11:0] len;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        lv;
    logic [11:0] li;
    int          cyc;
  } obs_t;

  typedef struct {
    int          nb;
    int          declen;
    logic [31:0] base;
  } pkt_t;

  typedef struct {
    logic [14:0] lvl;
    logic [11:0] len;
    logic        full;
    logic        admit;
  } adm_vec_t;

  beat_t srcq[NS][$];
  pkt_t  pk[NS][$];
  beat_t exp_q[$];
  obs_t  obs[$];

  logic          full_k;
  logic [14:0]   lvl_k;
  logic [NS-1:0] s_ready;
  logic          s_enq;
  logic          h_enq[256];
  int            ncyc, n_acc, first_acc;
  int            n_vec, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    logic [NS-1:0]    v, so, eo;
    logic [NS*DW-1:0] d;
    logic [NS*LW-1:0] l;
    @(negedge clk);
    v = '0; so = '0; eo = '0; d = '0; l = '0;
    for (int s = 0; s < NS; s++) begin
      if (srcq[s].size() > 0) begin
        v[s] = 1'b1;
        so[s] = srcq[s][0].sop;
        eo[s] = srcq[s][0].eop;
        d[s*DW +: DW] = srcq[s][0].data;
        l[s*LW +: LW] = srcq[s][0].len;
      end
    end
    bus.src_valid = v; bus.src_sop = so; bus.src_eop = eo;
    bus.src_data = d; bus.src_len = l;
    bus.pck_proc_full = full_k; bus.pck_proc_wr_lvl = lvl_k;
    #1;
    s_ready = bus.src_ready;
    s_enq = bus.enq_req;
    if (bus.enq_req)
      obs.push_back('{bus.wr_data_i, bus.in_sop, bus.in_eop, bus.pck_len_valid, bus.pck_len_i, ncyc});
    if (ncyc < 256) h_enq[ncyc] = bus.enq_req;
    for (int s = 0; s < NS; s++) begin
      if (v[s] && bus.src_ready[s]) begin
        void'(srcq[s].pop_front());
        if (first_acc < 0) first_acc = ncyc;
        n_acc++;
      end
    end
    ncyc++;
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++) begin
      srcq[s].delete();
      pk[s].delete();
    end
    obs.delete();
    exp_q.delete();
    ncyc = 0; n_acc = 0; first_acc = -1;
  endtask

  task automatic hard_reset();
    clear_all();
    full_k = 1'b0; lvl_k = '0;
    rstn = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    ncyc = 0; n_acc = 0; first_acc = -1;
    obs.delete();
  endtask

  task automatic add_pkt(input int s, input int nb, input int declen, input logic [31:0] base);
    for (int i = 0; i < nb; i++)
      srcq[s].push_back('{base + 32'(i), i == 0, i == nb - 1, 12'(declen)});
    pk[s].push_back('{nb, declen, base});
  endtask

  // Model: continuously-loaded sources are served one whole packet at a time,
  // in round-robin order starting from source 0 after reset.
  task automatic build_exp();
    int ptr, s;
    bit found;
    pkt_t p;
    ptr = 0;
    forever begin
      found = 0; s = 0;
      for (int k = 0; k < NS; k++) begin
        if (!found && pk[(ptr + k) % NS].size() > 0) begin
          found = 1;
          s = (ptr + k) % NS;
        end
      end
      if (!found) break;
      p = pk[s].pop_front();
      for (int i = 0; i < p.nb; i++)
        exp_q.push_back('{p.base + 32'(i), i == 0, i == p.nb - 1, 12'(p.declen)});
      ptr = (s + 1) % NS;
    end
  endtask

  task automatic run_until(input int n, input int budget, input bit rnd);
    int c;
    c = 0;
    while (obs.size() < n && c < budget) begin
      if (rnd) begin
        lvl_k = ($urandom_range(0, 3) == 0) ? 15'(16384 - $urandom_range(0, 10))
                                             : 15'($urandom_range(0, 16000));
        full_k = ($urandom_range(0, 4) == 0);
      end
      cyc();
      c++;
    end
    full_k = 1'b0;
    if (obs.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got %0d beats expected %0d", obs.size(), n);
    end
  endtask

  task automatic compare_stream(input string tag);
    int m;
    chk({tag, " beat count"}, obs.size(), exp_q.size());
    m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, " data"}, obs[i].data, exp_q[i].data);
      chk({tag, " sop"}, 32'(obs[i].sop), 32'(exp_q[i].sop));
      chk({tag, " eop"}, 32'(obs[i].eop), 32'(exp_q[i].eop));
      chk({tag, " len_valid"}, 32'(obs[i].lv), 32'(exp_q[i].sop));
      chk({tag, " len"}, 32'(obs[i].li), exp_q[i].sop ? 32'(exp_q[i].len) : 32'd0);
      if (i > 0 && obs[i].sop)
        chk({tag, " inter-packet gap"}, 32'(obs[i].cyc - obs[i-1].cyc >= 2), 32'd1);
    end
  endtask

  initial begin
    adm_vec_t tbl[10];
    int fa;
    n_vec = 0; n_err = 0;
    full_k = 1'b0; lvl_k = '0;
    clear_all();
    tbl[0] = '{15'd0,     12'd4, 1'b0, 1'b1};
    tbl[1] = '{15'd16380, 12'd4, 1'b0, 1'b1};
    tbl[2] = '{15'd16380, 12'd5, 1'b0, 1'b0};
    tbl[3] = '{15'd16383, 12'd0, 1'b0, 1'b1};
    tbl[4] = '{15'd16384, 12'd0, 1'b0, 1'b0};
    tbl[5] = '{15'd16376, 12'd8, 1'b0, 1'b1};
    tbl[6] = '{15'd16380, 12'd8, 1'b0, 1'b0};
    tbl[7] = '{15'd0,     12'd4, 1'b1, 1'b0};
    tbl[8] = '{15'd32767, 12'd1, 1'b0, 1'b0};
    tbl[9] = '{15'd16383, 12'd1, 1'b0, 1'b1};

    // Reset state
    cyc();
    chk("rst enq_req", 32'(bus.enq_req), 0);
    chk("rst src_ready", 32'(bus.src_ready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant_id", 32'(grant_id), 0);
    chk("rst errs", {30'd0, len_err, proto_err}, 0);

    // Single packet from src0
    hard_reset();
    add_pkt(0, 4, 4, 32'hA0);
    build_exp();
    repeat (10) cyc();
    chk("first accept cycle", first_acc, 2);
    fa = (first_acc < 0) ? 0 : first_acc;
    for (int k = 0; k < 6; k++)
      chk("enq_req window", 32'(h_enq[fa + k]), 32'(k >= 1 && k <= 4));
    compare_stream("single");
    chk("single len_err", 32'(len_err), 0);
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
    chk("pkt_cnt src0", 32'(pkt_cnt[15:0]), 1);
`endif

    // Admission table, separated by soft resets
    for (int i = 0; i < 10; i++) begin
      clear_all();
      sw_rstn = 1'b0;
      cyc();
      sw_rstn = 1'b1;
      cyc();
      chk("sw reset busy", 32'(busy), 0);
      add_pkt(1, 2, int'(tbl[i].len), 32'h100);
      lvl_k = tbl[i].lvl; full_k = tbl[i].full;
      repeat (3) cyc();
      chk("admit ready", 32'(s_ready[1]), 32'(tbl[i].admit));
      chk("admit busy", 32'(busy), 1);
      chk("admit grant", 32'(grant_id), 1);
    end

    // Fairness: all sources continuously loaded
    hard_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        add_pkt(s, 2, 2, 32'((s << 8) | (p << 4)));
    build_exp();
    run_until(exp_q.size(), 400, 0);
    compare_stream("fair");

    // Admission hold then release
    hard_reset();
    lvl_k = 15'd16380;
    add_pkt(1, 8, 8, 32'h300);
    build_exp();
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold ready", 32'(s_ready[1]), 0);
      chk("hold busy", 32'(busy), 1);
    end
    lvl_k = 15'd16376;
    cyc();
    chk("release ready t0", 32'(s_ready[1]), 0);
    cyc();
    chk("release ready t1", 32'(s_ready[1]), 1);
    run_until(exp_q.size(), 100, 0);
    compare_stream("hold");

    // Mid-packet stall
    hard_reset();
    add_pkt(0, 6, 6, 32'h400);
    build_exp();
    for (int i = 0; i < 20 && n_acc < 2; i++) cyc();
    full_k = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall ready", 32'(s_ready[0]), 0);
      chk("stall enq_req", 32'(s_enq), 32'(i == 0));
    end
    full_k = 1'b0;
    run_until(exp_q.size(), 100, 0);
    compare_stream("stall");

    // Short packet: declared 5, eop on beat 3
    hard_reset();
    add_pkt(3, 3, 5, 32'h500);
    build_exp();
    run_until(exp_q.size(), 100, 0);
    repeat (2) cyc();
    compare_stream("short");
    chk("short len_err", 32'(len_err), 1);
    chk("short proto_err", 32'(proto_err), 0);

    // Beat without sop while idle
    hard_reset();
    srcq[2].push_back('{32'h600, 1'b0, 1'b0, 12'd1});
    cyc();
    chk("stray ready", 32'(s_ready[2]), 1);
    cyc();
    chk("stray proto_err", 32'(proto_err), 1);
    chk("stray ready after", 32'(s_ready[2]), 0);
    repeat (3) cyc();
    chk("stray enq count", obs.size(), 0);
    chk("stray busy", 32'(busy), 0);
    chk("stray len_err", 32'(len_err), 0);

    // Async reset mid-packet, then clean packet from src2
    hard_reset();
    add_pkt(0, 5, 5, 32'h700);
    for (int i = 0; i < 20 && n_acc < 2; i++) cyc();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst enq_req", 32'(bus.enq_req), 0);
    chk("arst in_sop/eop", {30'd0, bus.in_sop, bus.in_eop}, 0);
    chk("arst data", bus.wr_data_i, 0);
    chk("arst len", {19'd0, bus.pck_len_valid, bus.pck_len_i}, 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst src_ready", 32'(bus.src_ready), 0);
    clear_all();
    cyc();
    rstn = 1'b1;
    ncyc = 0; obs.delete();
    add_pkt(2, 3, 3, 32'h800);
    build_exp();
    run_until(exp_q.size(), 100, 0);
    compare_stream("after arst");
    chk("after arst errs", {30'd0, len_err, proto_err}, 0);

    // Randomized traffic
    for (int it = 0; it < 3; it++) begin
      hard_reset();
      for (int s = 0; s < NS; s++) begin
        int np;
        np = $urandom_range(0, 4);
        for (int p = 0; p < np; p++) begin
          int nb;
          nb = $urandom_range(1, 6);
          add_pkt(s, nb, nb, 32'((it << 24) | (s << 16) | (p << 8)));
        end
      end
      build_exp();
      run_until(exp_q.size(), 20000, 1);
      compare_stream("random");
      chk("random errs", {30'd0, len_err, proto_err}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
